// File: rtl/bsr_chain.sv
// Boundary-scan register chain: input cells, output data cells,
// output-enable cells and two fixed cells (F1 = 1, F0 = 0).
// Parallel view BSR_OUT packs the cells as {input, data, enable, F1, F0},
// with the MSB nearest TDI and bit 0 (F0) driving TDO.
module bsr_chain #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
) (
    input  logic                          tck_i,
    input  logic                          trst_ni,
    input  logic                          tdi_i,
    output logic                          tdo_o,
    input  logic                          capture_i,
    input  logic                          shift_i,
    input  logic                          update_i,
    input  logic                          enable_i,
    input  logic [1:0]                    mode_i,
    input  logic [N_IN-1:0]               pin_in_i,
    output logic [N_IN-1:0]               core_out_o,
    input  logic [N_OUT-1:0]              core_in_i,
    input  logic [N_OUT-1:0]              core_oe_i,
    output logic [N_OUT-1:0]              pin_out_o,
    output logic [N_OUT-1:0]              pin_oe_o,
    output logic [N_IN+2*N_OUT+2-1:0]     bsr_out_o
);

    localparam int L  = N_IN + 2 * N_OUT + 2;
    // Update latches exist for every cell except F1/F0.
    localparam int NU = L - 2;

    localparam logic [1:0] MODE_SAMPLE = 2'b00;
    localparam logic [1:0] MODE_EXTEST = 2'b01;
    localparam logic [1:0] MODE_INTEST = 2'b10;
    localparam logic [1:0] MODE_CLAMP  = 2'b11;

    logic [L-1:0]  bsr_q, bsr_d;
    logic [NU-1:0] upd_q, upd_d;

    logic [N_IN-1:0]  upd_in_s;
    logic [N_OUT-1:0] upd_data_s;
    logic [N_OUT-1:0] upd_oe_s;

    assign upd_in_s   = upd_q[NU-1 -: N_IN];
    assign upd_data_s = upd_q[NU-N_IN-1 -: N_OUT];
    assign upd_oe_s   = upd_q[N_OUT-1:0];

    // Shift-stage next state: capture wins over shift; CLAMP captures F1/F0 only.
    always_comb begin
        bsr_d = bsr_q;
        if (enable_i && capture_i) begin
            if (mode_i == MODE_CLAMP) begin
                bsr_d[1] = 1'b1;
                bsr_d[0] = 1'b0;
            end else begin
                bsr_d = {pin_in_i, core_in_i, core_oe_i, 1'b1, 1'b0};
            end
        end else if (enable_i && shift_i) begin
            bsr_d = {tdi_i, bsr_q[L-1:1]};
        end else begin
            bsr_d = bsr_q;
        end
    end

    // Update-latch next state: copies the pre-edge shift stages, independent of capture/shift.
    always_comb begin
        upd_d = upd_q;
        if (enable_i && update_i) begin
            upd_d = bsr_q[L-1:2];
        end else begin
            upd_d = upd_q;
        end
    end

    // Shift stages and update latches, cleared asynchronously by TRST_N.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            bsr_q <= {L{1'b0}};
            upd_q <= {NU{1'b0}};
        end else begin
            bsr_q <= bsr_d;
            upd_q <= upd_d;
        end
    end

    // Pin/core muxes: purely combinational on MODE so a mode change acts immediately.
    always_comb begin
        core_out_o = pin_in_i;
        pin_out_o  = core_in_i;
        pin_oe_o   = core_oe_i;
        case (mode_i)
            MODE_SAMPLE: begin
                core_out_o = pin_in_i;
                pin_out_o  = core_in_i;
                pin_oe_o   = core_oe_i;
            end
            MODE_EXTEST: begin
                core_out_o = pin_in_i;
                pin_out_o  = upd_data_s;
                pin_oe_o   = upd_oe_s;
            end
            MODE_INTEST: begin
                core_out_o = upd_in_s;
                pin_out_o  = upd_data_s;
                pin_oe_o   = upd_oe_s;
            end
            MODE_CLAMP: begin
                core_out_o = pin_in_i;
                pin_out_o  = upd_data_s;
                pin_oe_o   = upd_oe_s;
            end
            default: begin
                core_out_o = pin_in_i;
                pin_out_o  = upd_data_s;
                pin_oe_o   = upd_oe_s;
            end
        endcase
    end

    assign tdo_o     = bsr_q[0];
    assign bsr_out_o = bsr_q;

endmodule

// File: tb/tb_bsr_chain.sv
// Directed self-checking bench for bsr_chain (N_IN=2, N_OUT=2, L=8).
// Expected values are pushed to a scoreboard queue when stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_bsr_chain;

    logic       tck;
    logic       trst_n;
    logic       tdi;
    logic       tdo;
    logic       capture;
    logic       shift;
    logic       update;
    logic       enable;
    logic [1:0] mode;
    logic [1:0] pin_in;
    logic [1:0] core_out;
    logic [1:0] core_in;
    logic [1:0] core_oe;
    logic [1:0] pin_out;
    logic [1:0] pin_oe;
    logic [7:0] bsr_out;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } sb_t;

    sb_t sb[$];
    int  tests = 0;
    int  fails = 0;

    bsr_chain #(.N_IN(2), .N_OUT(2)) dut (
        .tck_i      (tck),
        .trst_ni    (trst_n),
        .tdi_i      (tdi),
        .tdo_o      (tdo),
        .capture_i  (capture),
        .shift_i    (shift),
        .update_i   (update),
        .enable_i   (enable),
        .mode_i     (mode),
        .pin_in_i   (pin_in),
        .core_out_o (core_out),
        .core_in_i  (core_in),
        .core_oe_i  (core_oe),
        .pin_out_o  (pin_out),
        .pin_oe_o   (pin_oe),
        .bsr_out_o  (bsr_out)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic push(input string tag, input logic [7:0] v);
        sb_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [7:0] obs);
        sb_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    logic [7:0] exp_bsr;
    logic [7:0] cap_img;
    logic [7:0] shin;

    initial begin
        trst_n  = 1'b0;
        tdi     = 1'b0;
        capture = 1'b0;
        shift   = 1'b0;
        update  = 1'b0;
        enable  = 1'b0;
        mode    = 2'b01;
        pin_in  = 2'b00;
        core_in = 2'b00;
        core_oe = 2'b11;
        #3;
        // Reset state, sampled before any clock edge.
        push("rst_bsr", 8'h00);    chk(bsr_out);
        push("rst_tdo", 8'h00);    chk({7'd0, tdo});
        push("rst_pin_oe", 8'h00); chk({6'd0, pin_oe});
        trst_n = 1'b1;
        tick();

        // Capture.
        enable  = 1'b1;
        mode    = 2'b00;
        pin_in  = 2'b10;
        core_in = 2'b01;
        core_oe = 2'b11;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        cap_img = 8'b10_01_11_10;
        push("capture", cap_img); chk(bsr_out);

        // Shift out with TDI=0; TDO is the F0 stage first.
        shift = 1'b1;
        tdi   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push($sformatf("tdo_out_%0d", i), {7'd0, cap_img[i]});
            chk({7'd0, tdo});
            tick();
        end
        push("shift_out_zero", 8'h00); chk(bsr_out);

        // Shift in a pattern, LSB first, tracking it with a shift model.
        shin    = 8'b01_10_11_00;
        exp_bsr = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tdi = shin[i];
            tick();
            exp_bsr = {shin[i], exp_bsr[7:1]};
        end
        shift = 1'b0;
        push("shift_in", exp_bsr); chk(bsr_out);
        update = 1'b1;
        tick();
        update = 1'b0;

        // EXTEST: pins driven from latches while core toggles.
        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            core_in = 2'(i);
            core_oe = 2'(3 - i);
            pin_in  = 2'(i + 1);
            #1;
            push("extest_pin_out", 8'h02);       chk({6'd0, pin_out});
            push("extest_pin_oe", 8'h03);        chk({6'd0, pin_oe});
            push("extest_core_out", {6'd0, pin_in}); chk({6'd0, core_out});
        end

        // INTEST: core driven from input latches regardless of PIN_IN.
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            pin_in = 2'(i);
            #1;
            push("intest_core_out", 8'h01); chk({6'd0, core_out});
            push("intest_pin_out", 8'h02);  chk({6'd0, pin_out});
        end

        // SAMPLE: fully transparent.
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            pin_in  = 2'(i + 1);
            core_in = 2'(2 - i);
            core_oe = 2'(i);
            #1;
            push("sample_core_out", {6'd0, pin_in}); chk({6'd0, core_out});
            push("sample_pin_out", {6'd0, core_in}); chk({6'd0, pin_out});
            push("sample_pin_oe", {6'd0, core_oe});  chk({6'd0, pin_oe});
        end
        push("mode_keeps_state", exp_bsr); chk(bsr_out);

        // CLAMP: latched pins, capture only touches F1/F0.
        mode    = 2'b11;
        pin_in  = 2'b11;
        core_in = 2'b11;
        core_oe = 2'b00;
        #1;
        push("clamp_pin_out", 8'h02);   chk({6'd0, pin_out});
        push("clamp_pin_oe", 8'h03);    chk({6'd0, pin_oe});
        push("clamp_core_out", 8'h03);  chk({6'd0, core_out});
        capture = 1'b1;
        tick();
        capture = 1'b0;
        exp_bsr = {exp_bsr[7:2], 2'b10};
        push("clamp_capture", exp_bsr); chk(bsr_out);

        // Capture and shift together: capture wins.
        mode    = 2'b00;
        pin_in  = 2'b01;
        core_in = 2'b10;
        core_oe = 2'b00;
        capture = 1'b1;
        shift   = 1'b1;
        tdi     = 1'b1;
        tick();
        capture = 1'b0;
        exp_bsr = 8'b01_10_00_10;
        push("cap_over_shift", exp_bsr); chk(bsr_out);

        // Shift and update on the same edge: latches take pre-edge stages.
        update = 1'b1;
        tick();
        update  = 1'b0;
        shift   = 1'b0;
        exp_bsr = {1'b1, exp_bsr[7:1]};
        mode    = 2'b01;
        #1;
        push("shift_upd_bsr", exp_bsr); chk(bsr_out);
        push("shift_upd_pin_out", 8'h02); chk({6'd0, pin_out});
        push("shift_upd_pin_oe", 8'h00);  chk({6'd0, pin_oe});

        // ENABLE low: everything holds for 5 edges.
        enable  = 1'b0;
        capture = 1'b1;
        shift   = 1'b1;
        update  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        capture = 1'b0;
        update  = 1'b0;
        push("enable_low_bsr", exp_bsr); chk(bsr_out);
        push("enable_low_pin_out", 8'h02); chk({6'd0, pin_out});

        // Load latches so PIN_OE is nonzero before the reset test.
        enable = 1'b1;
        tdi    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_bsr = {1'b1, exp_bsr[7:1]};
        end
        shift  = 1'b0;
        push("preload_bsr", exp_bsr); chk(bsr_out);
        update = 1'b1;
        tick();
        update = 1'b0;
        push("preload_pin_oe", 8'h03); chk({6'd0, pin_oe});

        // Asynchronous reset in the middle of a shift.
        shift = 1'b1;
        tdi   = 1'b0;
        tick();
        #2;
        trst_n = 1'b0;
        #1;
        push("async_rst_bsr", 8'h00);    chk(bsr_out);
        push("async_rst_pin_oe", 8'h00); chk({6'd0, pin_oe});
        push("async_rst_tdo", 8'h00);    chk({7'd0, tdo});
        #1;
        trst_n  = 1'b1;
        shift   = 1'b0;
        capture = 1'b1;
        pin_in  = 2'b11;
        core_in = 2'b00;
        core_oe = 2'b01;
        tick();
        capture = 1'b0;
        push("post_rst_capture", 8'b11_00_01_10); chk(bsr_out);
        push("post_rst_pin_oe", 8'h00);           chk({6'd0, pin_oe});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
